// File: rtl/dot_product_folded_if.sv
// Handshake and data bundle for the folded attention-score dot-product stage.
// The slave view is taken by the datapath, the master view by whatever feeds it.
interface dot_product_folded_if #(
    parameter int DIM      = 64,
    parameter int IN_W     = 8,
    parameter int OUT_W    = 9,
    parameter int MAX_ROWS = 512
);
    localparam int RW = $clog2(MAX_ROWS + 1);

    logic                  q_vld_in;
    logic                  q_rdy_out;
    logic [DIM*IN_W-1:0]   q_in;
    logic [RW-1:0]         num_rows;
    logic [3:0]            scale_shift;

    logic                  k_vld_in;
    logic                  k_rdy_out;
    logic [DIM*IN_W-1:0]   k_in;

    logic                  v_vld_in;
    logic                  v_rdy_out;
    logic [DIM*IN_W-1:0]   v_in;

    logic                  vld_out;
    logic                  rdy_in;
    logic [OUT_W-1:0]      s_out;
    logic [DIM*IN_W-1:0]   v_out;
    logic                  last_out;
    logic                  busy;

    modport slave (
        input  q_vld_in, q_in, num_rows, scale_shift,
        input  k_vld_in, k_in, v_vld_in, v_in, rdy_in,
        output q_rdy_out, k_rdy_out, v_rdy_out,
        output vld_out, s_out, v_out, last_out, busy
    );

    modport master (
        output q_vld_in, q_in, num_rows, scale_shift,
        output k_vld_in, k_in, v_vld_in, v_in, rdy_in,
        input  q_rdy_out, k_rdy_out, v_rdy_out,
        input  vld_out, s_out, v_out, last_out, busy
    );
endinterface

// File: rtl/dot_product_folded.sv
// Folded attention-score stage: one Q vector is held while a programmable number
// of K/V rows stream through. Each row's Q.K is accumulated LANES products per
// beat, scaled by an arithmetic right shift, saturated to OUT_W and forwarded
// together with its V vector and a last-row flag.
// Parameter constraints: DIM % LANES == 0, OUT_F <= 2*IN_F,
// ACC_W >= 2*IN_W + clog2(DIM).
module dot_product_folded #(
    parameter int DIM      = 64,
    parameter int LANES    = 8,
    parameter int IN_W     = 8,
    parameter int IN_F     = 7,
    parameter int OUT_W    = 9,
    parameter int OUT_F    = 4,
    parameter int ACC_W    = 24,
    parameter int MAX_ROWS = 512
) (
    input  logic                clk,
    input  logic                rst,
    dot_product_folded_if.slave bus
);
    localparam int BEATS     = DIM / LANES;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RW        = $clog2(MAX_ROWS + 1);
    localparam int VW        = DIM * IN_W;
    localparam int IDX_W     = $clog2(VW);
    localparam int FRAC_DROP = 2 * IN_F - OUT_F;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    // Slots
    logic              rdy_en;
    logic              q_held;
    logic [VW-1:0]     q_reg;
    logic [3:0]        shift_reg;
    logic [RW-1:0]     rows_left;
    logic              k_full;
    logic [VW-1:0]     k_reg;
    logic              v_full;
    logic [VW-1:0]     v_reg;

    // MAC
    state_t                   state;
    logic [BEAT_W-1:0]        beat;
    logic signed [ACC_W-1:0]  acc;

    // Output register
    logic              vld_r;
    logic [OUT_W-1:0]  s_r;
    logic [VW-1:0]     v_r;
    logic              last_r;

    // Combinational
    logic                     q_hs, k_hs, v_hs;
    logic [RW-1:0]            rows_clamped;
    logic                     beat_active;
    logic [BEAT_W-1:0]        cur_beat;
    logic signed [ACC_W-1:0]  acc_base;
    logic                     is_final;
    logic                     out_write;
    int unsigned              elem;
    logic signed [IN_W-1:0]   q_e, k_e;
    logic signed [2*IN_W-1:0] prod;
    logic signed [ACC_W-1:0]  beat_sum, total, shifted, scaled;
    logic [OUT_W-1:0]         s_sat;

    assign bus.q_rdy_out = rdy_en && !q_held;
    assign bus.k_rdy_out = q_held && !k_full && (rows_left != '0);
    assign bus.v_rdy_out = q_held && !v_full && (rows_left != '0);
    assign bus.vld_out   = vld_r;
    assign bus.s_out     = s_r;
    assign bus.v_out     = v_r;
    assign bus.last_out  = last_r;
    assign bus.busy      = q_held || vld_r;

    assign q_hs = bus.q_vld_in && bus.q_rdy_out;
    assign k_hs = bus.k_vld_in && bus.k_rdy_out;
    assign v_hs = bus.v_vld_in && bus.v_rdy_out;

    assign rows_clamped = (bus.num_rows > RW'(MAX_ROWS)) ? RW'(MAX_ROWS) : bus.num_rows;

    // Beat 0 runs in the IDLE cycle that sees both slots full, so the first
    // product lands one cycle after the last K/V handshake.
    assign beat_active = ((state == S_IDLE) && k_full && v_full) || (state == S_MAC);
    assign cur_beat    = (state == S_MAC) ? beat : '0;
    assign acc_base    = (state == S_MAC) ? acc : '0;
    assign is_final    = (cur_beat == BEAT_W'(BEATS - 1));
    assign out_write   = beat_active && is_final && (!vld_r || bus.rdy_in);

    // Lane products for the current beat, then scale and saturate the running total
    always_comb begin
        elem     = 0;
        q_e      = '0;
        k_e      = '0;
        prod     = '0;
        beat_sum = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            elem     = 32'(cur_beat) * LANES + l;
            q_e      = q_reg[IDX_W'(elem * IN_W) +: IN_W];
            k_e      = k_reg[IDX_W'(elem * IN_W) +: IN_W];
            prod     = q_e * k_e;
            beat_sum = beat_sum + ACC_W'(prod);
        end
        total   = acc_base + beat_sum;
        shifted = total >>> shift_reg;
        scaled  = shifted >>> FRAC_DROP;
        if ((&scaled[ACC_W-1:OUT_W-1]) || !(|scaled[ACC_W-1:OUT_W-1])) begin
            s_sat = scaled[OUT_W-1:0];
        end else if (scaled[ACC_W-1]) begin
            s_sat = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            s_sat = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    // Q/K/V slot bookkeeping; handshakes and the output write never coincide on a slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en    <= 1'b0;
            q_held    <= 1'b0;
            q_reg     <= '0;
            shift_reg <= '0;
            rows_left <= '0;
            k_full    <= 1'b0;
            k_reg     <= '0;
            v_full    <= 1'b0;
            v_reg     <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (q_hs) begin
                q_reg     <= bus.q_in;
                shift_reg <= bus.scale_shift;
                rows_left <= rows_clamped;
                q_held    <= (rows_clamped != '0);
            end
            if (k_hs) begin
                k_full <= 1'b1;
                k_reg  <= bus.k_in;
            end
            if (v_hs) begin
                v_full <= 1'b1;
                v_reg  <= bus.v_in;
            end
            if (out_write) begin
                k_full    <= 1'b0;
                v_full    <= 1'b0;
                rows_left <= rows_left - RW'(1);
                if (rows_left == RW'(1)) begin
                    q_held <= 1'b0;
                end
            end
        end
    end

    // MAC sequencer: step beats, hold the final beat while the output is blocked
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            beat  <= '0;
            acc   <= '0;
        end else begin
            case (state)
                S_IDLE, S_MAC: begin
                    if (beat_active) begin
                        if (!is_final) begin
                            acc   <= total;
                            beat  <= cur_beat + BEAT_W'(1);
                            state <= S_MAC;
                        end else if (out_write) begin
                            beat  <= '0;
                            state <= S_DONE;
                        end else begin
                            acc   <= acc_base;
                            beat  <= cur_beat;
                            state <= S_MAC;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output register: load on the final beat, clear when consumed without refill
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_r  <= 1'b0;
            s_r    <= '0;
            v_r    <= '0;
            last_r <= 1'b0;
        end else if (out_write) begin
            vld_r  <= 1'b1;
            s_r    <= s_sat;
            v_r    <= v_reg;
            last_r <= (rows_left == RW'(1));
        end else if (vld_r && bus.rdy_in) begin
            vld_r  <= 1'b0;
            s_r    <= '0;
            v_r    <= '0;
            last_r <= 1'b0;
        end
    end
endmodule
